alu_muldiv: RTL and testbench

Multi-cycle signed multiply/divide unit that owns the HI/LO register pair. It is the consuming end of the ALU control encoding: it receives the 5-bit AluCtrl codes produced by the ALU control decoder and executes the mult, div, mfhi and mflo operations. It sits beside the single-cycle ALU in EX. While an operation is in flight it interlocks the pipeline.

---
 rtl/alu_ctrl_pkg.sv | 57 +++++
 rtl/alu_muldiv_if.sv | 35 +++
 rtl/alu_muldiv_step.sv | 56 +++++
 rtl/alu_muldiv.sv | 208 ++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared ALU control encoding plus the multiply/divide unit's
//               FSM state encoding and counter sizing helper.
//               Codes are consumed by alu_muldiv and produced by the ALU
//               control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    // 5-bit AluCtrl codes
    localparam logic [4:0] c_ALU_AND  = 5'b00000;
    localparam logic [4:0] c_ALU_MFLO = 5'b00001;
    localparam logic [4:0] c_ALU_ADD  = 5'b00010;
    localparam logic [4:0] c_ALU_XOR  = 5'b00011;
    localparam logic [4:0] c_ALU_NOR  = 5'b00100;
    localparam logic [4:0] c_ALU_SLTU = 5'b00101;
    localparam logic [4:0] c_ALU_SUB  = 5'b00110;
    localparam logic [4:0] c_ALU_SLT  = 5'b00111;
    localparam logic [4:0] c_ALU_MULT = 5'b01000;
    localparam logic [4:0] c_ALU_SLL  = 5'b01001;
    localparam logic [4:0] c_ALU_DIV  = 5'b01010;
    localparam logic [4:0] c_ALU_SRL  = 5'b01011;
    localparam logic [4:0] c_ALU_SRA  = 5'b01100;
    localparam logic [4:0] c_ALU_LUI  = 5'b01101;
    localparam logic [4:0] c_ALU_OR   = 5'b01110;
    localparam logic [4:0] c_ALU_MFHI = 5'b01111;

    // Multiply/divide FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } muldivState_t;

    // Operation latched at issue; selects the fix-up applied in S_FIX
    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_DIV  = 2'd1,
        OP_DIVZ = 2'd2
    } muldivOp_t;

    // Iteration datapath mode
    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } stepMode_t;

    // Counter must hold the value WIDTH itself
    function automatic int cntWidth(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_if
// Description : Request/response bundle between the EX stage and the
//               multiply/divide unit.
//   master : drives Start, AluCtrl, A, B; observes the rest
//   slave  : the alu_muldiv unit
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic             Start;
    logic [4:0]       AluCtrl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic             Stall;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             DivByZero;

    modport master (
        output Start, AluCtrl, A, B,
        input  Busy, Done, Stall, Result, Hi, Lo, DivByZero
    );

    modport slave (
        input  Start, AluCtrl, A, B,
        output Busy, Done, Stall, Result, Hi, Lo, DivByZero
    );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One iteration of the multi-cycle multiply/divide datapath.
//   MODE_MUL : i_acc = product accumulator, i_opA = multiplicand (shifted
//              left each step), i_opB = remaining multiplier bits (shifted
//              right each step). Adds i_opA when the multiplier LSB is set.
//   MODE_DIV : i_acc[WIDTH:0] = partial remainder, i_opA[WIDTH-1:0] =
//              divisor, i_opB = dividend bits shifting out MSB-first while
//              quotient bits shift in at the LSB (restoring division).
// Ports       : i_mode, i_acc, i_opA, i_opB -> o_acc, o_opA, o_opB
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  stepMode_t          i_mode,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [2*WIDTH-1:0] i_opA,
    input  logic [WIDTH-1:0]   i_opB,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [2*WIDTH-1:0] o_opA,
    output logic [WIDTH-1:0]   o_opB
);
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH+1:0] w_diff;

    // Remainder shifted left with the next dividend bit brought in; the
    // extra MSB of w_diff is the borrow that decides restore vs keep.
    assign w_shifted = {i_acc[WIDTH-1:0], i_opB[WIDTH-1]};
    assign w_diff    = {1'b0, w_shifted} - {2'b00, i_opA[WIDTH-1:0]};

    always_comb begin
        o_acc = i_acc;
        o_opA = i_opA;
        o_opB = i_opB;
        if (i_mode == MODE_MUL) begin
            if (i_opB[0]) begin
                o_acc = i_acc + i_opA;
            end
            o_opA = {i_opA[2*WIDTH-2:0], 1'b0};
            o_opB = {1'b0, i_opB[WIDTH-1:1]};
        end else begin
            if (!w_diff[WIDTH+1]) begin
                o_acc = {{(WIDTH-1){1'b0}}, w_diff[WIDTH:0]};
                o_opB = {i_opB[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {{(WIDTH-1){1'b0}}, w_shifted};
                o_opB = {i_opB[WIDTH-2:0], 1'b0};
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv
// Description : Multi-cycle signed multiply/divide unit owning HI/LO.
//               Executes mult, div, mfhi, mflo from AluCtrl; interlocks the
//               pipeline via Stall while an operation is in flight.
// Ports       : clk, rst_n (async active-low), bus (alu_muldiv_if.slave:
//               Start, AluCtrl, A, B in; Busy, Done, Stall, Result, Hi, Lo,
//               DivByZero out)
// Options     : ALU_MULDIV_EARLY_TERM_EN - multiply stops as soon as the
//               remaining multiplier bits are zero (results unchanged).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire         clk,
    input  wire         rst_n,
    alu_muldiv_if.slave bus
);
    localparam int c_CNT_W = cntWidth(WIDTH);

`ifdef ALU_MULDIV_EARLY_TERM_EN
    localparam bit c_EARLY_TERM = 1'b1;
`else
    localparam bit c_EARLY_TERM = 1'b0;
`endif

    muldivState_t       r_state;
    muldivState_t       w_stateNext;
    muldivOp_t          r_op;
    logic [c_CNT_W-1:0] r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_opA;
    logic [WIDTH-1:0]   r_opB;
    logic               r_signA;
    logic               r_signB;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_divZero;

    logic               w_isMult;
    logic               w_isDiv;
    logic               w_isMove;
    logic               w_busy;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic [2*WIDTH-1:0] w_accStep;
    logic [2*WIDTH-1:0] w_opAStep;
    logic [WIDTH-1:0]   w_opBStep;
    logic [2*WIDTH-1:0] w_prodSigned;
    logic [WIDTH-1:0]   w_quoSigned;
    logic [WIDTH-1:0]   w_remSigned;
    stepMode_t          w_mode;

    assign w_isMult = (bus.AluCtrl == c_ALU_MULT);
    assign w_isDiv  = (bus.AluCtrl == c_ALU_DIV);
    assign w_isMove = (bus.AluCtrl == c_ALU_MFHI) || (bus.AluCtrl == c_ALU_MFLO);

    // Two's-complement negate of the most negative value yields itself,
    // which read as unsigned is exactly its magnitude.
    assign w_absA = bus.A[WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
    assign w_absB = bus.B[WIDTH-1] ? (~bus.B + 1'b1) : bus.B;

    assign w_mode = (r_state == S_DIV) ? MODE_DIV : MODE_MUL;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_mode (w_mode),
        .i_acc  (r_acc),
        .i_opA  (r_opA),
        .i_opB  (r_opB),
        .o_acc  (w_accStep),
        .o_opA  (w_opAStep),
        .o_opB  (w_opBStep)
    );

    // Sign fix-up applied in S_FIX
    assign w_prodSigned = (r_signA ^ r_signB) ? (~r_acc + 1'b1) : r_acc;
    assign w_quoSigned  = (r_signA ^ r_signB) ? (~r_opB + 1'b1) : r_opB;
    assign w_remSigned  = r_signA ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (bus.Start && w_isMult) begin
                    w_stateNext = S_MUL;
                end else if (bus.Start && w_isDiv) begin
                    w_stateNext = (bus.B == '0) ? S_FIX : S_DIV;
                end
            end
            S_MUL: begin
                // Early exit once no multiplier bits remain to be consumed
                if ((r_count == c_CNT_W'(1)) || (c_EARLY_TERM && (w_opBStep == '0))) begin
                    w_stateNext = S_FIX;
                end
            end
            S_DIV: begin
                if (r_count == c_CNT_W'(1)) begin
                    w_stateNext = S_FIX;
                end
            end
            S_FIX: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= OP_MUL;
            r_count   <= '0;
            r_acc     <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_signA   <= 1'b0;
            r_signB   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_divZero <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_divZero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.Start && (w_isMult || w_isDiv)) begin
                        r_signA <= bus.A[WIDTH-1];
                        r_signB <= bus.B[WIDTH-1];
                        r_count <= c_CNT_W'(WIDTH);
                        r_acc   <= '0;
                        if (w_isMult) begin
                            r_op  <= OP_MUL;
                            r_opA <= {{WIDTH{1'b0}}, w_absA};
                            r_opB <= w_absB;
                        end else if (bus.B == '0) begin
                            // Dividend kept raw; it becomes HI unchanged
                            r_op  <= OP_DIVZ;
                            r_opA <= '0;
                            r_opB <= bus.A;
                        end else begin
                            r_op  <= OP_DIV;
                            r_opA <= {{WIDTH{1'b0}}, w_absB};
                            r_opB <= w_absA;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    r_acc   <= w_accStep;
                    r_opA   <= w_opAStep;
                    r_opB   <= w_opBStep;
                    r_count <= r_count - c_CNT_W'(1);
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    case (r_op)
                        OP_MUL: begin
                            r_hi <= w_prodSigned[2*WIDTH-1:WIDTH];
                            r_lo <= w_prodSigned[WIDTH-1:0];
                        end
                        OP_DIV: begin
                            r_hi <= w_remSigned;
                            r_lo <= w_quoSigned;
                        end
                        default: begin
                            r_hi      <= r_opB;
                            r_lo      <= '1;
                            r_divZero <= 1'b1;
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------ outputs
    assign bus.Busy      = w_busy;
    assign bus.Done      = r_done;
    assign bus.DivByZero = r_divZero;
    assign bus.Hi        = r_hi;
    assign bus.Lo        = r_lo;
    assign bus.Stall     = (w_isMove || (bus.Start && (w_isMult || w_isDiv))) && w_busy;
    assign bus.Result    = (bus.AluCtrl == c_ALU_MFHI) ? r_hi :
                           (bus.AluCtrl == c_ALU_MFLO) ? r_lo : '0;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv
// Description : Scoreboard bench for alu_muldiv. Stimulus pushes expected
//               HI/LO/DivByZero and Done cycle; a monitor pops on Done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv;
    import alu_ctrl_pkg::*;

    localparam int WIDTH = 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          doneCyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cycle;
    int   nTests;
    int   nFail;
    int   doneSeen;
    exp_t sbq[$];

    alu_muldiv_if #(.WIDTH(WIDTH)) bus ();

    alu_muldiv #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int bitLen(input longint v);
        int n = 0;
        while (v > 0) begin
            n++;
            v = v / 2;
        end
        return n;
    endfunction

    // Reference model from the arithmetic definition of signed mult/div
    function automatic exp_t model(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.doneCyc = 0;
        if (ctrl == c_ALU_MULT) begin
            v    = sa * sb;
            e.hi = v[63:32];
            e.lo = v[31:0];
            e.dz = 1'b0;
`ifdef ALU_MULDIV_EARLY_TERM_EN
            e.lat = ((bitLen(sb < 0 ? -sb : sb) < 1) ? 1 : bitLen(sb < 0 ? -sb : sb)) + 1;
`else
            e.lat = WIDTH + 1;
`endif
        end else if (b == 32'd0) begin
            e.hi  = a;
            e.lo  = 32'hFFFF_FFFF;
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            q     = sa / sb;
            r     = sa % sb;
            v     = q;
            e.lo  = v[31:0];
            v     = r;
            e.hi  = v[31:0];
            e.dz  = 1'b0;
            e.lat = WIDTH + 1;
        end
        return e;
    endfunction

    // Monitor: every Done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && bus.Done) begin
            exp_t e;
            doneSeen++;
            if (sbq.size() == 0) begin
                nTests++;
                nFail++;
                $display("FAIL unexpectedDone: got Done=1 expected no outstanding op (t=%0t)", $time);
            end else begin
                e = sbq.pop_front();
                check("hi", {32'd0, bus.Hi}, {32'd0, e.hi});
                check("lo", {32'd0, bus.Lo}, {32'd0, e.lo});
                check("divByZero", {63'd0, bus.DivByZero}, {63'd0, e.dz});
                check("doneCycle", 64'(cycle), 64'(e.doneCyc));
            end
        end
    end

    // Called just after a negedge; leaves Start low one negedge later
    task automatic issue(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bus.Start   = 1'b1;
        bus.AluCtrl = ctrl;
        bus.A       = a;
        bus.B       = b;
        if (ctrl == c_ALU_MULT || ctrl == c_ALU_DIV) begin
            e         = model(ctrl, a, b);
            e.doneCyc = cycle + 1 + e.lat;
            sbq.push_back(e);
        end
        @(negedge clk);
        bus.Start   = 1'b0;
        bus.AluCtrl = c_ALU_ADD;
    endtask

    task automatic waitDone();
        int start = doneSeen;
        int n = 0;
        while (doneSeen == start && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (doneSeen == start) begin
            nTests++;
            nFail++;
            $display("FAIL doneTimeout: got no Done expected Done within 200 cycles");
        end
        @(negedge clk);
    endtask

    task automatic runOp(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        issue(ctrl, a, b);
        waitDone();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t        e;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rc;
        int          n;
        bit          seen;

        nTests      = 0;
        nFail       = 0;
        doneSeen    = 0;
        rst_n       = 1'b0;
        bus.Start   = 1'b0;
        bus.AluCtrl = c_ALU_ADD;
        bus.A       = '0;
        bus.B       = '0;

        repeat (3) @(negedge clk);
        check("rstHi", {32'd0, bus.Hi}, 64'd0);
        check("rstLo", {32'd0, bus.Lo}, 64'd0);
        check("rstBusy", {63'd0, bus.Busy}, 64'd0);
        check("rstDone", {63'd0, bus.Done}, 64'd0);
        check("rstDivByZero", {63'd0, bus.DivByZero}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Non-muldiv code with Start is ignored
        issue(c_ALU_SUB, 32'd5, 32'd6);
        check("ignoredCodeBusy", {63'd0, bus.Busy}, 64'd0);

        // Directed cases
        runOp(c_ALU_MULT, 32'd7, 32'hFFFF_FFFD);
        runOp(c_ALU_DIV, 32'hFFFF_FFF9, 32'd2);
        runOp(c_ALU_DIV, 32'd100, 32'd0);
        runOp(c_ALU_MULT, 32'h8000_0000, 32'h8000_0000);
        runOp(c_ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp(c_ALU_MULT, 32'd5, 32'd3);
        runOp(c_ALU_MULT, 32'h1234_5678, 32'd0);

        // mflo interlock, with a second Start while Busy
        e = model(c_ALU_MULT, 32'h0000_1234, 32'hFFFF_FFFB);
        issue(c_ALU_MULT, 32'h0000_1234, 32'hFFFF_FFFB);
        repeat (2) @(negedge clk);
        bus.Start   = 1'b1;
        bus.AluCtrl = c_ALU_DIV;
        bus.A       = 32'd9;
        bus.B       = 32'd3;
        #1;
        check("stallStartWhileBusy", {63'd0, bus.Stall}, 64'd1);
        @(negedge clk);
        bus.Start   = 1'b0;
        bus.AluCtrl = c_ALU_ADD;
        @(negedge clk);
        bus.AluCtrl = c_ALU_MFLO;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            #1;
            if (bus.Done) begin
                seen = 1'b1;
                check("stallAtDone", {63'd0, bus.Stall}, 64'd0);
                check("resultAtDone", {32'd0, bus.Result}, {32'd0, e.lo});
            end else begin
                check("stallWhileBusy", {63'd0, bus.Stall}, 64'd1);
                @(negedge clk);
                n++;
            end
        end
        if (!seen) begin
            nTests++;
            nFail++;
            $display("FAIL mfloTimeout: got no Done expected Done within 100 cycles");
        end
        bus.AluCtrl = c_ALU_MFHI;
        #1;
        check("mfhiResult", {32'd0, bus.Result}, {32'd0, e.hi});
        @(negedge clk);
        bus.AluCtrl = c_ALU_ADD;
        repeat (3) @(negedge clk);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            rc = ($urandom_range(0, 1) == 0) ? c_ALU_MULT : c_ALU_DIV;
            case ($urandom_range(0, 3))
                0: ra = $urandom;
                1: ra = 32'($urandom_range(0, 255));
                2: ra = 32'h8000_0000;
                default: ra = -32'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 4))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(0, 15));
                2: rb = -32'($urandom_range(1, 15));
                3: rb = 32'hFFFF_FFFF;
                default: rb = 32'h8000_0000;
            endcase
            runOp(rc, ra, rb);
        end

        // Asynchronous reset in the middle of a divide
        runOp(c_ALU_MULT, 32'd1234, 32'd5678);
        issue(c_ALU_DIV, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midRstHi", {32'd0, bus.Hi}, 64'd0);
        check("midRstLo", {32'd0, bus.Lo}, 64'd0);
        check("midRstBusy", {63'd0, bus.Busy}, 64'd0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("postRstBusy", {63'd0, bus.Busy}, 64'd0);
        check("outstanding", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
`default_nettype wire
